muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Multi-cycle M-extension execution unit that consumes the 4-bit alu_control codes for mul, div and rem. It sits in the EX stage beside the single-cycle ALU. It accepts one operation per start/done handshake and produces a 32-bit result. The pipeline stalls on busy until done.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
alu_control  input  4  op code: 4'b1011 mul, 4'b1100 div (signed), 4'b1101 rem (signed)
op_a  input  XLEN  rs1 / dividend / multiplicand
op_b  input  XLEN  rs2 / divisor / multiplier
flush  input  1  synchronous abort from hazard/branch logic
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
result  output  XLEN  operation result; held until next accepted start

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE accepting a start:
  - Accepted when start=1 and alu_control is one of the three codes; other codes are ignored and the state stays IDLE.
  - Operands and opcode latched on the accepting edge; later input changes have no effect.
- IDLE -> DONE directly (special cases, 1 edge):
  - div, op_b=0: result=all ones.
  - rem, op_b=0: result=op_a.
  - div, op_a=0x80000000 and op_b=0xFFFFFFFF: result=0x80000000.
  - rem, same overflow operands: result=0.
- IDLE -> CALC otherwise, counter=0.
- CALC, one iteration per edge, counter increments; after the XLEN-th iteration -> FIX.
  - mul: unsigned shift-add of the raw operands. Low XLEN bits are identical for signed and unsigned, so no sign handling; only low XLEN product bits are kept.
  - div/rem: restoring division on |op_a| and |op_b|, one quotient bit per edge, 2*XLEN-bit remainder/quotient register.
- FIX (1 edge):
  - div: negate quotient if sign(op_a) != sign(op_b).
  - rem: remainder takes the sign of op_a.
  - mul: pass-through.
  - result written; -> DONE.
- DONE: done=1 for exactly this cycle, busy=1; next edge -> IDLE.
- Latency:
  - Normal op: done high XLEN+2 edges after the accepting edge (34 for XLEN=32).
  - Special case: 1 edge.
- start while busy: ignored, no queuing.
- flush=1 in any state: next edge -> IDLE, no done pulse, result keeps its previous value. flush has priority over start on the same edge.
- rst mid-operation: immediate return to reset values; no done.
- done and busy both drop on the edge leaving DONE. A start in the cycle after DONE is accepted normally (back-to-back allowed, one idle cycle minimum).

Decomposition:
- Shared package muldiv_pkg:
  - ALU_MUL=4'b1011, ALU_DIV=4'b1100, ALU_REM=4'b1101 (same encoding the ALU control decoder emits).
  - Enum state_t {IDLE, CALC, FIX, DONE}.
  - XLEN default constant.
  - Pure function div_step (compare/subtract/shift of one restoring iteration).
- No sub-module: the datapath and FSM are small enough for one module; div_step keeps the iteration logic testable.

Test Plan:
- mul 7 * 0xFFFFFFFD (-3): done after 34 edges, result=0xFFFFFFEB (-21); busy high for 34 edges.
- div 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA (-6); rem same operands -> 0xFFFFFFFE (-2); div 20 / -3 -> 0xFFFFFFFA.
- div 5 / 0 -> 0xFFFFFFFF in 1 edge; rem 5 / 0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000, rem -> 0, each 1 edge.
- Start mul 3*4, then start=1 with div operands in cycle 5 -> div ignored, result=12 at edge 34; unsupported code 4'b0010 with start -> busy stays 0.
- Start div 100/7, flush at cycle 10 -> IDLE next edge, no done, result unchanged; then start rem 100/7 -> 2 after 34 edges.
- Start mul, assert rst at cycle 15 asynchronously -> busy=0, done=0, result=0 immediately; new mul 6*7 after release -> 42.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and the restoring-division step for the M-extension unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_MUL = 4'b1011;
  localparam logic [3:0] ALU_DIV = 4'b1100;
  localparam logic [3:0] ALU_REM = 4'b1101;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // One restoring iteration on {remainder, quotient}: shift, trial-subtract, set quotient bit.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] rq,
                                                 input logic [XLEN-1:0]   divisor);
    logic [2*XLEN-1:0] sh;
    sh = {rq[2*XLEN-2:0], 1'b0};
    if (sh[2*XLEN-1:XLEN] >= divisor) begin
      sh[2*XLEN-1:XLEN] = sh[2*XLEN-1:XLEN] - divisor;
      sh[0] = 1'b1;
    end
    return sh;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle mul/div/rem unit: shift-add multiply, restoring signed divide, start/done handshake.
module muldiv_unit #(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import muldiv_pkg::*;

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t            state, state_next;
  logic [3:0]        op;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mcand, mplier, product, divisor;
  logic [2*XLEN-1:0] rq;
  logic [CNT_W-1:0]  count;

  logic            valid_op, is_div, is_rem, div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] abs_a, abs_b, special_result, fixed_result, quot, rem;

  always_comb begin
    valid_op = (alu_control == ALU_MUL) || (alu_control == ALU_DIV) || (alu_control == ALU_REM);
    is_div   = (alu_control == ALU_DIV);
    is_rem   = (alu_control == ALU_REM);
    div_zero = (op_b == '0);
    div_ovf  = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = (is_div || is_rem) && (div_zero || div_ovf);
    accept   = (state == IDLE) && start && valid_op && !flush;
    abs_a    = op_a[XLEN-1] ? -op_a : op_a;
    abs_b    = op_b[XLEN-1] ? -op_b : op_b;
    // Overflow div returns op_a (0x80000000) unchanged, same path as rem-by-zero.
    if (is_div) special_result = div_zero ? '1 : op_a;
    else        special_result = div_zero ? op_a : '0;
  end

  always_comb begin
    quot = rq[XLEN-1:0];
    rem  = rq[2*XLEN-1:XLEN];
    if (op == ALU_DIV)      fixed_result = (sign_a ^ sign_b) ? -quot : quot;
    else if (op == ALU_REM) fixed_result = sign_a ? -rem : rem;
    else                    fixed_result = product;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = special ? DONE : CALC;
      CALC: if (count == CNT_W'(XLEN-1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op      <= '0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      divisor <= '0;
      rq      <= '0;
      count   <= '0;
      result  <= '0;
    end else if (accept) begin
      op      <= alu_control;
      sign_a  <= op_a[XLEN-1];
      sign_b  <= op_b[XLEN-1];
      mcand   <= op_a;
      mplier  <= op_b;
      product <= '0;
      divisor <= abs_b;
      rq      <= {{XLEN{1'b0}}, abs_a};
      count   <= '0;
      if (special) result <= special_result;
    end else if (!flush && state == CALC) begin
      // Multiply and divide datapaths both advance; FIX picks the one matching op.
      product <= product + (mplier[0] ? mcand : '0);
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      rq      <= div_step(rq, divisor);
      count   <= count + 1'b1;
    end else if (!flush && state == FIX) begin
      result <= fixed_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus randomized ops against a reference model.
module tb_muldiv_unit;
  localparam logic [3:0] MUL = 4'b1011;
  localparam logic [3:0] DIV = 4'b1100;
  localparam logic [3:0] REM = 4'b1101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  alu_control = 4'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check32(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  // Reference: RISC-V M semantics straight from signed arithmetic.
  function automatic void ref_model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output int lat);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 34;
    if (ctl == MUL) begin
      r = sa * sb;
    end else if (b == 0) begin
      lat = 1;
      r = (ctl == DIV) ? -1 : sa;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lat = 1;
      r = (ctl == DIV) ? sa : 0;
    end else begin
      r = (ctl == DIV) ? (sa / sb) : (sa % sb);
    end
    res = r[31:0];
  endfunction

  // Monitor: pops the scoreboard whenever done is presented.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%h required=no_done", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check32({e.tag, "_result"}, result, e.res);
        check32({e.tag, "_latency"}, 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        $display("op %s result=%h latency=%0d", e.tag, result, cyc - e.acc_cyc + 1);
      end
    end
  end

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout actual=busy required=idle", name);
    end
  endtask

  // Drives one request; returns at the negedge following the accepting edge.
  task automatic issue(string tag, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    exp_t e;
    @(negedge clk);
    wait_idle(tag);
    if (expect_done) begin
      e.tag = tag;
      ref_model(ctl, a, b, e.res, e.lat);
      e.acc_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    start = 1'b1;
    alu_control = ctl;
    op_a = a;
    op_b = b;
    @(negedge clk);
    start = 1'b0;
    alu_control = ($urandom_range(0, 1) == 0) ? DIV : MUL;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  initial begin
    logic [31:0] prev, a, b;
    logic [3:0]  ctl;
    int          n;

    repeat (2) @(negedge clk);
    check32("reset_busy", 32'(busy), 32'd0);
    check32("reset_done", 32'(done), 32'd0);
    check32("reset_result", result, 32'd0);
    rst = 1'b0;

    // Busy duration of a normal op.
    issue("mul_7_m3", MUL, 32'd7, 32'hFFFF_FFFD, 1'b1);
    n = 1;
    for (int i = 0; i < 100 && busy; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check32("mul_busy_cycles", 32'(n), 32'd34);

    issue("div_m20_3", DIV, 32'hFFFF_FFEC, 32'd3, 1'b1);
    issue("rem_m20_3", REM, 32'hFFFF_FFEC, 32'd3, 1'b1);
    issue("div_20_m3", DIV, 32'd20, 32'hFFFF_FFFD, 1'b1);
    issue("div_5_0", DIV, 32'd5, 32'd0, 1'b1);
    issue("rem_5_0", REM, 32'd5, 32'd0, 1'b1);
    issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

    // A start while busy must be dropped.
    issue("mul_3_4", MUL, 32'd3, 32'd4, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1; alu_control = DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_idle("mul_3_4");

    // Unsupported opcode never leaves IDLE.
    @(negedge clk);
    start = 1'b1; alu_control = 4'b0010;
    @(negedge clk);
    check32("unsupported_busy", 32'(busy), 32'd0);
    start = 1'b0;

    // Flush mid-divide: no done, result untouched.
    @(negedge clk);
    prev = result;
    issue("div_flushed", DIV, 32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check32("flush_busy", 32'(busy), 32'd0);
    check32("flush_result", result, prev);
    repeat (40) @(negedge clk);
    issue("rem_100_7", REM, 32'd100, 32'd7, 1'b1);
    wait_idle("rem_100_7");

    // Asynchronous reset mid-multiply.
    issue("mul_reset", MUL, 32'h0000_1234, 32'd5, 1'b0);
    repeat (13) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check32("async_rst_busy", 32'(busy), 32'd0);
    check32("async_rst_done", 32'(done), 32'd0);
    check32("async_rst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue("mul_6_7", MUL, 32'd6, 32'd7, 1'b1);

    // Randomized ops, occasionally hitting the divide special cases.
    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(0, 2);
      ctl = (n == 0) ? MUL : (n == 1) ? DIV : REM;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      issue("rand", ctl, a, b, 1'b1);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check32("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
